// File: rtl/alu64_if.sv
// rtl/alu64_if.sv - operand/result bundle for alu64 (zero_flag/sign_flag only with ALU64_CC_EN)
interface alu64_if;
   logic [63:0] num1;
   logic [63:0] num2;
   logic [1:0]  operation;
   logic [63:0] result;
   logic        overflow_flag;
`ifdef ALU64_CC_EN
   logic        zero_flag;
   logic        sign_flag;
`endif

   modport master (
      output num1, num2, operation,
`ifdef ALU64_CC_EN
      input  zero_flag, sign_flag,
`endif
      input  result, overflow_flag
   );

   modport slave (
      input  num1, num2, operation,
`ifdef ALU64_CC_EN
      output zero_flag, sign_flag,
`endif
      output result, overflow_flag
   );
endinterface

// File: rtl/alu64.sv
// rtl/alu64.sv - 64-bit registered ADD/SUB/AND/XOR ALU; condition codes enabled by ALU64_CC_EN
module alu64 (
   input logic   clk,
   input logic   rst,
   alu64_if.slave bus
);
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_XOR = 2'b11;

   logic [63:0] a, b, b_eff, sum, carry;
   logic        sub;

   assign a     = bus.num1;
   assign b     = bus.num2;
   assign sub   = (bus.operation == OP_SUB);
   // SUB reuses the adder: invert B and inject the +1 as carry-in.
   assign b_eff = sub ? ~b : b;
   assign carry[0] = sub;

   // Ripple chain of full-adder cells; the final carry-out is never formed.
   for (genvar i = 0; i < 64; i++) begin : g_fa
      assign sum[i] = a[i] ^ b_eff[i] ^ carry[i];
      if (i < 63) begin : g_cy
         assign carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
      end
   end

   logic [63:0] result_d, result_q;
   logic        ovf_d, ovf_q;

   // Select the result and signed overflow for the current operation.
   always_comb begin
      result_d = sum;
      ovf_d    = 1'b0;
      case (bus.operation)
         OP_ADD, OP_SUB: begin
            result_d = sum;
            // Overflow when the effective addends agree in sign but the sum does not.
            ovf_d    = (a[63] == b_eff[63]) && (sum[63] != a[63]);
         end
         OP_AND: result_d = a & b;
         OP_XOR: result_d = a ^ b;
         default: result_d = sum;
      endcase
   end

   // Output registers; reset discards whatever was sampled at that edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         result_q <= result_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.result        = result_q;
   assign bus.overflow_flag = ovf_q;

`ifdef ALU64_CC_EN
   logic zero_q, sign_q;

   // Condition codes derived from the same next result as result_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         zero_q <= 1'b1;
         sign_q <= 1'b0;
      end else begin
         zero_q <= (result_d == 64'd0);
         sign_q <= result_d[63];
      end
   end

   assign bus.zero_flag = zero_q;
   assign bus.sign_flag = sign_q;
`endif
endmodule

// File: tb/tb_alu64.sv
// tb/tb_alu64.sv - scoreboard bench for alu64 (define ALU64_CC_EN to also check condition codes)
module tb_alu64;
   logic clk = 1'b0;
   logic rst;
   alu64_if bus ();

   alu64 dut (.clk(clk), .rst(rst), .bus(bus.slave));

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [63:0] res;
      logic        ovf;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   bit   done  = 1'b0;

   // Drive one vector at the negedge and queue the response expected after the next posedge.
   task automatic issue(input string name, input logic r, input logic [63:0] n1,
                        input logic [63:0] n2, input logic [1:0] op,
                        input logic [63:0] e_res, input logic e_ovf);
      exp_t e;
      rst           = r;
      bus.num1      = n1;
      bus.num2      = n2;
      bus.operation = op;
      e.name = name;
      e.res  = e_res;
      e.ovf  = e_ovf;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   // Independent golden model for the random phase.
   task automatic golden(input logic [63:0] n1, input logic [63:0] n2, input logic [1:0] op,
                         output logic [63:0] r, output logic v);
      v = 1'b0;
      case (op)
         2'b00: begin r = n1 + n2; v = (n1[63] == n2[63]) && (r[63] != n1[63]); end
         2'b01: begin r = n1 - n2; v = (n1[63] != n2[63]) && (r[63] != n1[63]); end
         2'b10: r = n1 & n2;
         default: r = n1 ^ n2;
      endcase
   endtask

   // Monitor: the DUT presents a new output every cycle; compare it with the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (bus.result !== e.res) begin
               bad++;
               $display("FAIL %s result: got %h want %h", e.name, bus.result, e.res);
            end
            total++;
            if (bus.overflow_flag !== e.ovf) begin
               bad++;
               $display("FAIL %s overflow: got %b want %b", e.name, bus.overflow_flag, e.ovf);
            end
`ifdef ALU64_CC_EN
            total++;
            if (bus.zero_flag !== (e.res == 64'd0)) begin
               bad++;
               $display("FAIL %s zero_flag: got %b want %b", e.name, bus.zero_flag, (e.res == 64'd0));
            end
            total++;
            if (bus.sign_flag !== e.res[63]) begin
               bad++;
               $display("FAIL %s sign_flag: got %b want %b", e.name, bus.sign_flag, e.res[63]);
            end
`endif
         end
      end
   end

   initial begin
      logic [63:0] n1, n2, r;
      logic [1:0]  op;
      logic        v;
      // Reset with non-zero inputs present: outputs must still clear.
      issue("reset",      1'b1, 64'd9, 64'd9, 2'b00, 64'd0, 1'b0);
      issue("and_neg5",   1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd107, 2'b10, 64'd107, 1'b0);
      issue("add_ovf",    1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 64'h8000_0000_0000_0000, 1'b1);
      issue("sub_ovf",    1'b0, 64'h8000_0000_0000_0000, 64'd1, 2'b01, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
      issue("sub_zero",   1'b0, 64'd5, 64'd5, 2'b01, 64'd0, 1'b0);
      issue("xor",        1'b0, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, 2'b11, 64'hF00F_F00F_F00F_F00F, 1'b0);
      issue("rst_mid",    1'b1, 64'd3, 64'd4, 2'b00, 64'd0, 1'b0);
      issue("after_rst",  1'b0, 64'd3, 64'd4, 2'b00, 64'd7, 1'b0);
      issue("add_m1_p1",  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 64'd0, 1'b0);
      issue("add_minmin", 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b00, 64'd0, 1'b1);
      issue("sub_0_min",  1'b0, 64'd0, 64'h8000_0000_0000_0000, 2'b01, 64'h8000_0000_0000_0000, 1'b1);
      issue("sub_neg",    1'b0, 64'd3, 64'd10, 2'b01, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0);
      issue("and_full",   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0, 2'b10, 64'h1234_5678_9ABC_DEF0, 1'b0);
      issue("add_plain",  1'b0, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF, 2'b00, 64'h0000_0001_FFFF_FFFF, 1'b0);
      for (int i = 0; i < 20; i++) begin
         n1 = {$urandom, $urandom};
         n2 = {$urandom, $urandom};
         op = 2'(i % 4);
         golden(n1, n2, op, r, v);
         issue($sformatf("rand%0d", i), 1'b0, n1, n2, op, r, v);
      end
      // Allow the last expectation to drain, bounded to a few cycles.
      for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      done = 1'b1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
